ghost_event_ctrl: RTL and testbench

GHOST_EVENT_CTRL -- requirements
Module: ghost_event_ctrl

---
 rtl/ghost_event_pkg.sv | 38 +++
 rtl/ghost_respawn_timer.sv | 51 +++++
 rtl/ghost_event_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ghost_event_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_event_pkg.sv
// Shared types and constants for the ghost event controller: FSM states,
// default frame counts, ghost bit positions and the eat-chain score table.
package ghost_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_FRIGHT = 3'd2,
        ST_DEATH  = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam int DEF_FRIGHT_FRAMES  = 360;
    localparam int DEF_DEATH_FRAMES   = 120;
    localparam int DEF_RESPAWN_FRAMES = 180;
    localparam int DEF_START_LIVES    = 3;

    // Wide enough for any sensible frame count; all timers share it.
    localparam int TMR_W = 16;

    localparam int NUM_GHOSTS   = 3;
    localparam int GHOST_TINKY  = 0;
    localparam int GHOST_STINKY = 1;
    localparam int GHOST_CLYDE  = 2;

    localparam logic [10:0] SCORE_CHAIN0 = 11'd200;
    localparam logic [10:0] SCORE_CHAIN1 = 11'd400;
    localparam logic [10:0] SCORE_CHAIN2 = 11'd800;

    function automatic logic [10:0] chain_score(input logic [1:0] chain);
        case (chain)
            2'd0:    chain_score = SCORE_CHAIN0;
            2'd1:    chain_score = SCORE_CHAIN1;
            default: chain_score = SCORE_CHAIN2;
        endcase
    endfunction

endpackage

// File: rtl/ghost_respawn_timer.sv
// Per-ghost pen timer: load sends the ghost home for RESPAWN_FRAMES frames,
// clear releases it immediately. Runs regardless of the game state.
module ghost_respawn_timer
    import ghost_event_pkg::*;
#(
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic frame_tick,
    input  logic clear,
    output logic home
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             home_q, home_d;

    // A tick in the load cycle is swallowed so the full count is honoured.
    always_comb begin
        cnt_d  = cnt_q;
        home_d = home_q;
        if (clear) begin
            cnt_d  = '0;
            home_d = 1'b0;
        end else if (load) begin
            cnt_d  = TMR_W'(RESPAWN_FRAMES);
            home_d = 1'b1;
        end else if (home_q && frame_tick) begin
            if (cnt_q <= TMR_W'(1)) begin
                cnt_d  = '0;
                home_d = 1'b0;
            end else begin
                cnt_d = cnt_q - TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            home_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            home_q <= home_d;
        end
    end

    assign home = home_q;

endmodule

// File: rtl/ghost_event_ctrl.sv
// Game event controller: tracks play/fright/death/over, lives, the eat chain
// and per-ghost pen state, and emits registered one-cycle event pulses.
module ghost_event_ctrl
    import ghost_event_pkg::*;
#(
    parameter int FRIGHT_FRAMES  = DEF_FRIGHT_FRAMES,
    parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter int START_LIVES    = DEF_START_LIVES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        pellet_eaten,
    input  logic [3:0]  collide,
    output logic        eat_time,
    output logic [2:0]  ghost_eaten,
    output logic [2:0]  ghost_home,
    output logic [10:0] score_add,
    output logic        score_valid,
    output logic        pac_death,
    output logic        round_restart,
    output logic [1:0]  lives,
    output logic        game_over,
    output state_t      dbg_state
);

    state_t            state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [TMR_W-1:0]  fright_q, fright_d;
    logic [TMR_W-1:0]  death_q, death_d;
    logic [1:0]        chain_q, chain_d;
    logic              eat_time_q, eat_time_d;
    logic              game_over_q, game_over_d;
    logic [2:0]        ghost_eaten_q, ghost_eaten_d;
    logic [10:0]       score_add_q, score_add_d;
    logic              score_valid_q, score_valid_d;
    logic              pac_death_q, pac_death_d;
    logic              restart_q, restart_d;

    logic [2:0]        eat_sel;
    logic [2:0]        respawn_load;
    logic              home_clear;
    logic [2:0]        ghost_home_w;

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        fright_d      = fright_q;
        death_d       = death_q;
        chain_d       = chain_q;
        ghost_eaten_d = '0;
        score_add_d   = '0;
        score_valid_d = 1'b0;
        pac_death_d   = 1'b0;
        restart_d     = 1'b0;
        eat_sel       = '0;
        respawn_load  = '0;
        home_clear    = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d    = ST_PLAY;
                    lives_d    = 2'(START_LIVES);
                    chain_d    = '0;
                    fright_d   = '0;
                    restart_d  = 1'b1;
                    home_clear = 1'b1;
                end
            end
            ST_PLAY: begin
                if (pellet_eaten) begin
                    state_d  = ST_FRIGHT;
                    fright_d = TMR_W'(FRIGHT_FRAMES);
                    chain_d  = '0;
                end else if (collide[0]) begin
                    state_d     = ST_DEATH;
                    pac_death_d = 1'b1;
                    lives_d     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    death_d     = TMR_W'(DEATH_FRAMES);
                    home_clear  = 1'b1;
                end
            end
            ST_FRIGHT: begin
                if (pellet_eaten) begin
                    fright_d = TMR_W'(FRIGHT_FRAMES);
                    chain_d  = '0;
                end else begin
                    if (frame_tick) begin
                        if (fright_q <= TMR_W'(1)) begin
                            state_d  = ST_PLAY;
                            fright_d = '0;
                        end else begin
                            fright_d = fright_q - TMR_W'(1);
                        end
                    end
                    // One ghost per cycle; clyde > stinky > tinky on a tie.
                    if (collide[3] && !ghost_home_w[GHOST_CLYDE]) begin
                        eat_sel[GHOST_CLYDE] = 1'b1;
                    end else if (collide[2] && !ghost_home_w[GHOST_STINKY]) begin
                        eat_sel[GHOST_STINKY] = 1'b1;
                    end else if (collide[1] && !ghost_home_w[GHOST_TINKY]) begin
                        eat_sel[GHOST_TINKY] = 1'b1;
                    end
                    if (eat_sel != 3'b000) begin
                        ghost_eaten_d = eat_sel;
                        respawn_load  = eat_sel;
                        score_valid_d = 1'b1;
                        score_add_d   = chain_score(chain_q);
                        chain_d       = (chain_q >= 2'd2) ? 2'd2 : chain_q + 2'd1;
                    end
                end
            end
            ST_DEATH: begin
                if (frame_tick) begin
                    if (death_q <= TMR_W'(1)) begin
                        death_d = '0;
                        if (lives_q == 2'd0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d    = ST_PLAY;
                            restart_d  = 1'b1;
                            home_clear = 1'b1;
                        end
                    end else begin
                        death_d = death_q - TMR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        eat_time_d  = (state_d == ST_FRIGHT);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lives_q       <= 2'(START_LIVES);
            fright_q      <= '0;
            death_q       <= '0;
            chain_q       <= '0;
            eat_time_q    <= 1'b0;
            game_over_q   <= 1'b0;
            ghost_eaten_q <= '0;
            score_add_q   <= '0;
            score_valid_q <= 1'b0;
            pac_death_q   <= 1'b0;
            restart_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            fright_q      <= fright_d;
            death_q       <= death_d;
            chain_q       <= chain_d;
            eat_time_q    <= eat_time_d;
            game_over_q   <= game_over_d;
            ghost_eaten_q <= ghost_eaten_d;
            score_add_q   <= score_add_d;
            score_valid_q <= score_valid_d;
            pac_death_q   <= pac_death_d;
            restart_q     <= restart_d;
        end
    end

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_respawn
        ghost_respawn_timer #(
            .RESPAWN_FRAMES(RESPAWN_FRAMES)
        ) u_timer (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (respawn_load[g]),
            .frame_tick (frame_tick),
            .clear      (home_clear),
            .home       (ghost_home_w[g])
        );
    end

    assign eat_time      = eat_time_q;
    assign ghost_eaten   = ghost_eaten_q;
    assign ghost_home    = ghost_home_w;
    assign score_add     = score_add_q;
    assign score_valid   = score_valid_q;
    assign pac_death     = pac_death_q;
    assign round_restart = restart_q;
    assign lives         = lives_q;
    assign game_over     = game_over_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ghost_event_ctrl.sv
// Directed bench for ghost_event_ctrl with short frame counts (8/4/6) and
// frame_tick held high so every cycle is one frame.
module tb_ghost_event_ctrl;
    import ghost_event_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        frame_tick;
    logic        pellet_eaten;
    logic [3:0]  collide;
    logic        eat_time;
    logic [2:0]  ghost_eaten;
    logic [2:0]  ghost_home;
    logic [10:0] score_add;
    logic        score_valid;
    logic        pac_death;
    logic        round_restart;
    logic [1:0]  lives;
    logic        game_over;
    state_t      dbg_state;

    int vectors;
    int miscompares;

    ghost_event_ctrl #(
        .FRIGHT_FRAMES  (8),
        .DEATH_FRAMES   (4),
        .RESPAWN_FRAMES (6),
        .START_LIVES    (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .frame_tick    (frame_tick),
        .pellet_eaten  (pellet_eaten),
        .collide       (collide),
        .eat_time      (eat_time),
        .ghost_eaten   (ghost_eaten),
        .ghost_home    (ghost_home),
        .score_add     (score_add),
        .score_valid   (score_valid),
        .pac_death     (pac_death),
        .round_restart (round_restart),
        .lives         (lives),
        .game_over     (game_over),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 ns past it before anything is sampled.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_collide(input logic [3:0] c);
        collide = c;
        step(1);
        collide = 4'b0000;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        frame_tick   = 1'b1;
        pellet_eaten = 1'b0;
        collide      = 4'b0000;

        // Reset state
        step(3);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_eat_time", 32'(eat_time), 32'd0);
        chk("rst_home", 32'(ghost_home), 32'd0);
        chk("rst_pulses", {26'd0, score_valid, pac_death, round_restart, game_over, 2'b00}, 32'd0);
        rst_n = 1'b1;
        step(2);
        chk("idle_hold", 32'(dbg_state), 32'(ST_IDLE));

        // Start, pellet, eat clyde two cycles later
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_restart", 32'(round_restart), 32'd1);
        chk("start_state", 32'(dbg_state), 32'(ST_PLAY));
        chk("start_lives", 32'(lives), 32'd3);
        step(1);
        chk("restart_one_cycle", 32'(round_restart), 32'd0);
        pellet_eaten = 1'b1;
        step(1);
        pellet_eaten = 1'b0;
        chk("pellet_eat_time", 32'(eat_time), 32'd1);
        step(1);
        pulse_collide(4'b1000);
        chk("eat1_ghost_eaten", 32'(ghost_eaten), 32'b100);
        chk("eat1_score_valid", 32'(score_valid), 32'd1);
        chk("eat1_score", 32'(score_add), 32'd200);
        chk("eat1_home", 32'(ghost_home), 32'b100);
        step(1);
        chk("eat1_pulse_drop", 32'(ghost_eaten), 32'd0);
        step(4);
        chk("eat1_home_6th", 32'(ghost_home), 32'b100);
        step(1);
        chk("eat1_home_clear", 32'(ghost_home), 32'b000);
        chk("fright_expired", 32'(eat_time), 32'd0);
        chk("back_to_play", 32'(dbg_state), 32'(ST_PLAY));

        // Eat chain 200/400/800, ignore home ghost, saturate chain
        pellet_eaten = 1'b1;
        step(1);
        pellet_eaten = 1'b0;
        pulse_collide(4'b1000);
        chk("chain0_score", 32'(score_add), 32'd200);
        pulse_collide(4'b0100);
        chk("chain1_eaten", 32'(ghost_eaten), 32'b010);
        chk("chain1_score", 32'(score_add), 32'd400);
        pulse_collide(4'b0010);
        chk("chain2_eaten", 32'(ghost_eaten), 32'b001);
        chk("chain2_score", 32'(score_add), 32'd800);
        chk("chain2_home", 32'(ghost_home), 32'b111);
        pulse_collide(4'b1000);
        chk("home_ignored_valid", 32'(score_valid), 32'd0);
        chk("home_ignored_eaten", 32'(ghost_eaten), 32'd0);
        pulse_collide(4'b0001);
        chk("fright_pac_hit_ignored", 32'(pac_death), 32'd0);
        chk("fright_pac_hit_state", 32'(dbg_state), 32'(ST_FRIGHT));
        step(2);
        pulse_collide(4'b1000);
        chk("chain_sat_score", 32'(score_add), 32'd800);
        chk("chain_sat_eaten", 32'(ghost_eaten), 32'b100);
        chk("chain_sat_home", 32'(ghost_home), 32'b101);
        chk("chain_sat_expiry", 32'(eat_time), 32'd0);
        step(8);
        chk("all_home_clear", 32'(ghost_home), 32'b000);

        // Pellet beats a same-cycle pac hit in PLAY
        pellet_eaten = 1'b1;
        collide      = 4'b0001;
        step(1);
        pellet_eaten = 1'b0;
        collide      = 4'b0000;
        chk("pellet_wins_state", 32'(dbg_state), 32'(ST_FRIGHT));
        chk("pellet_wins_death", 32'(pac_death), 32'd0);
        chk("pellet_wins_lives", 32'(lives), 32'd3);

        // Pellet on the expiry cycle keeps FRIGHT for 8 more frames
        step(7);
        chk("pre_expiry_eat_time", 32'(eat_time), 32'd1);
        pellet_eaten = 1'b1;
        step(1);
        pellet_eaten = 1'b0;
        chk("reload_at_expiry", 32'(eat_time), 32'd1);
        step(7);
        chk("reload_8th_frame", 32'(eat_time), 32'd1);
        step(1);
        chk("reload_expired", 32'(eat_time), 32'd0);

        // Three deaths down to game over, then restart
        for (int d = 0; d < 3; d++) begin
            pulse_collide(4'b0001);
            chk("death_pulse", 32'(pac_death), 32'd1);
            chk("death_lives", 32'(lives), 32'(2 - d));
            chk("death_state", 32'(dbg_state), 32'(ST_DEATH));
            pellet_eaten = 1'b1;
            collide      = 4'b0001;
            step(1);
            pellet_eaten = 1'b0;
            collide      = 4'b0000;
            chk("death_ignores_inputs", 32'(dbg_state), 32'(ST_DEATH));
            chk("death_no_second_pulse", 32'(pac_death), 32'd0);
            step(2);
            chk("death_still_frozen", 32'(dbg_state), 32'(ST_DEATH));
            step(1);
            if (d < 2) begin
                chk("death_restart", 32'(round_restart), 32'd1);
                chk("death_to_play", 32'(dbg_state), 32'(ST_PLAY));
            end else begin
                chk("over_no_restart", 32'(round_restart), 32'd0);
                chk("over_flag", 32'(game_over), 32'd1);
            end
        end
        step(2);
        chk("over_holds", 32'(game_over), 32'd1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("over_start_lives", 32'(lives), 32'd3);
        chk("over_start_flag", 32'(game_over), 32'd0);
        chk("over_start_restart", 32'(round_restart), 32'd1);

        // Reset mid-FRIGHT with a ghost in the pen
        step(1);
        pellet_eaten = 1'b1;
        step(1);
        pellet_eaten = 1'b0;
        pulse_collide(4'b0100);
        chk("pre_reset_home", 32'(ghost_home), 32'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("async_rst_eat_time", 32'(eat_time), 32'd0);
        chk("async_rst_home", 32'(ghost_home), 32'b000);
        chk("async_rst_lives", 32'(lives), 32'd3);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("post_rst_pulses", {28'd0, score_valid, pac_death, round_restart, eat_time}, 32'd0);
        chk("post_rst_eaten", 32'(ghost_eaten), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
